// File: rtl/inference_scoreboard.sv
// inference_scoreboard: scores classifier samples against labels and reports running accuracy
// via a serial restoring divider, one quotient bit per cycle.
module inference_scoreboard #(
    parameter int NUM_CLASSES = 10,
    parameter int MAX_INPUTS  = 200,
    parameter int MODE        = 0,
    parameter int ACC_W       = 9,
    localparam int CNT_W = $clog2(MAX_INPUTS + 1),
    localparam int NUM_W = CNT_W + 7
) (
    input  logic                   clk,
    input  logic                   rst_overall_n,
    input  logic                   clear,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic [NUM_CLASSES-1:0] expected,
    input  logic [NUM_CLASSES-1:0] obtained,
    output logic [CNT_W-1:0]       count,
    output logic [CNT_W-1:0]       correct,
    output logic [ACC_W-1:0]       accuracy,
    output logic                   acc_valid,
    output logic                   match_last,
    output logic                   run_done
);
    localparam int SW = $clog2(NUM_W + 1);
    localparam logic [SW-1:0]    LAST = SW'(NUM_W);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_INPUTS);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state;

    logic [NUM_W-1:0] num;
    logic [CNT_W-1:0] rem;
    logic [SW-1:0]    step;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] correct_nx;
    logic             match;
    logic             ge;

    assign match = (MODE == 0) ? ((expected == obtained) && (|obtained))
                               : ($onehot(obtained) && (|(expected & obtained)));
    assign correct_nx   = correct + CNT_W'(match);
    assign rem_sh       = {rem, num[NUM_W-1]};
    assign ge           = rem_sh >= {1'b0, count};
    assign sample_ready = state == IDLE;

    // num holds the dividend on entry to DIV and is shifted into the quotient as it drains
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state      <= IDLE;
            count      <= '0;
            correct    <= '0;
            accuracy   <= '0;
            acc_valid  <= 1'b0;
            match_last <= 1'b0;
            run_done   <= 1'b0;
            num        <= '0;
            rem        <= '0;
            step       <= '0;
        end else if (clear) begin
            state      <= IDLE;
            count      <= '0;
            correct    <= '0;
            accuracy   <= '0;
            acc_valid  <= 1'b0;
            match_last <= 1'b0;
            run_done   <= 1'b0;
            num        <= '0;
            rem        <= '0;
            step       <= '0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE: if (sample_valid) begin
                    count      <= count + 1'b1;
                    correct    <= correct_nx;
                    match_last <= match;
                    num        <= NUM_W'(correct_nx) * NUM_W'(100);
                    rem        <= '0;
                    step       <= '0;
                    state      <= DIV;
                end
                DIV: if (step == LAST) begin
                    accuracy  <= ACC_W'(num);
                    acc_valid <= 1'b1;
                    run_done  <= count == FULL;
                    state     <= (count == FULL) ? DONE : IDLE;
                end else begin
                    rem  <= CNT_W'(ge ? rem_sh - {1'b0, count} : rem_sh);
                    num  <= {num[NUM_W-2:0], ge};
                    step <= step + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inference_scoreboard.sv
// tb_inference_scoreboard: directed scoreboard bench over exact-match, one-hot and
// full-length (200 sample) configurations sharing one stimulus bus.
module tb_inference_scoreboard;
    logic       clk = 0;
    logic       rst_n, clear, sample_valid;
    logic [9:0] expected, obtained;
    int         sel;
    int         compared = 0;
    int         mismatched = 0;
    int         q[$];

    logic       r0, r1, r2, av0, av1, av2, ml0, ml1, ml2, rd0, rd1, rd2;
    logic [2:0] n0, n1, c0, c1;
    logic [7:0] n2, c2;
    logic [8:0] a0, a1, a2;

    logic       ready_s, av_s, ml_s, rd_s;
    logic [7:0] count_s, correct_s;
    logic [8:0] acc_s;

    always #5 clk = ~clk;

    inference_scoreboard #(.NUM_CLASSES(10), .MAX_INPUTS(4), .MODE(0), .ACC_W(9)) u0 (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .sample_ready(r0), .expected(expected), .obtained(obtained), .count(n0),
        .correct(c0), .accuracy(a0), .acc_valid(av0), .match_last(ml0), .run_done(rd0));
    inference_scoreboard #(.NUM_CLASSES(10), .MAX_INPUTS(4), .MODE(1), .ACC_W(9)) u1 (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .sample_ready(r1), .expected(expected), .obtained(obtained), .count(n1),
        .correct(c1), .accuracy(a1), .acc_valid(av1), .match_last(ml1), .run_done(rd1));
    inference_scoreboard #(.NUM_CLASSES(10), .MAX_INPUTS(200), .MODE(0), .ACC_W(9)) u2 (
        .clk(clk), .rst_overall_n(rst_n), .clear(clear), .sample_valid(sample_valid),
        .sample_ready(r2), .expected(expected), .obtained(obtained), .count(n2),
        .correct(c2), .accuracy(a2), .acc_valid(av2), .match_last(ml2), .run_done(rd2));

    assign ready_s   = sel == 2 ? r2  : sel == 1 ? r1  : r0;
    assign av_s      = sel == 2 ? av2 : sel == 1 ? av1 : av0;
    assign ml_s      = sel == 2 ? ml2 : sel == 1 ? ml1 : ml0;
    assign rd_s      = sel == 2 ? rd2 : sel == 1 ? rd1 : rd0;
    assign count_s   = sel == 2 ? n2  : sel == 1 ? {5'b0, n1} : {5'b0, n0};
    assign correct_s = sel == 2 ? c2  : sel == 1 ? {5'b0, c1} : {5'b0, c0};
    assign acc_s     = sel == 2 ? a2  : sel == 1 ? a1 : a0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".count"}, count_s, 0);
        chk({tag, ".correct"}, correct_s, 0);
        chk({tag, ".accuracy"}, acc_s, 0);
        chk({tag, ".acc_valid"}, av_s, 0);
        chk({tag, ".match_last"}, ml_s, 0);
        chk({tag, ".run_done"}, rd_s, 0);
        chk({tag, ".ready"}, ready_s, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one sample, then wait (bounded) for its accuracy pulse and score it
    task automatic send(input logic [9:0] e, input logic [9:0] o, input bit m,
                        input int nw, input int exp_acc);
        int k;
        expected = e;
        obtained = o;
        sample_valid = 1;
        chk("ready_before_accept", ready_s, 1);
        q.push_back(exp_acc);
        tick();
        sample_valid = 0;
        chk("match_last", ml_s, m);
        k = 0;
        while (!av_s && k < 40) begin
            tick();
            k++;
        end
        chk("acc_latency", k, nw + 1);
        if (av_s) chk("accuracy", acc_s, q.pop_front());
        tick();
        chk("acc_pulse_width", av_s, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hits;
        sel = 0;
        rst_n = 0;
        clear = 0;
        sample_valid = 0;
        expected = '0;
        obtained = '0;
        #3;
        all_zero("in_reset");
        tick();
        tick();
        rst_n = 1;
        tick();
        all_zero("after_release");

        send(10'b0000000100, 10'b0000000100, 1, 10, 100);
        chk("single.count", count_s, 1);
        chk("single.correct", correct_s, 1);

        clear = 1;
        tick();
        clear = 0;
        all_zero("cleared");
        send(10'b0000001000, 10'b0000001000, 1, 10, 100);
        send(10'b0000001000, 10'b0000000000, 0, 10, 50);
        send(10'b0000100000, 10'b0000100000, 1, 10, 66);
        chk("seq.count", count_s, 3);
        chk("seq.correct", correct_s, 2);
        chk("seq.run_done", rd_s, 0);
        send(10'b1000000000, 10'b1000000000, 1, 10, 75);
        chk("full.run_done", rd_s, 1);
        chk("full.ready", ready_s, 0);

        sample_valid = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("done_hold.count", count_s, 4);
        chk("done_hold.accuracy", acc_s, 75);
        chk("done_hold.run_done", rd_s, 1);
        clear = 1;
        tick();
        clear = 0;
        sample_valid = 0;
        all_zero("clear_beats_sample");
        tick();
        all_zero("clear_idle");

        expected = 10'b0000000001;
        obtained = 10'b0000000001;
        sample_valid = 1;
        tick();
        sample_valid = 0;
        chk("pre_reset.count", count_s, 1);
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        all_zero("async_reset_mid_div");
        #2 rst_n = 1;
        tick();
        all_zero("post_reset");

        sel = 1;
        send(10'b0000000011, 10'b0000000010, 1, 10, 100);
        send(10'b0000000011, 10'b0000000110, 0, 10, 50);
        send(10'b0000000011, 10'b0000000000, 0, 10, 33);
        chk("onehot.count", count_s, 3);
        chk("onehot.correct", correct_s, 1);
        chk("onehot.accuracy", acc_s, 33);

        sel = 2;
        clear = 1;
        tick();
        clear = 0;
        all_zero("long_cleared");
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            bit h;
            h = (i % 4) != 0;
            hits += int'(h);
            send(10'b0000010000, h ? 10'b0000010000 : 10'b0000100000, h, 15,
                 (hits * 100) / (i + 1));
        end
        chk("long.run_done", rd_s, 1);
        chk("long.count", count_s, 200);
        chk("long.correct", correct_s, 150);
        chk("long.accuracy", acc_s, 75);
        chk("long.ready", ready_s, 0);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
